// File: rtl/cram_store.sv
// CRAM microstore array, microinstruction register, diagnostic chunk loader and chunk readback.
// Optional build macro: CRAM_PARITY_CHECK_EN enables the registered odd-parity check on fetched words.
module cram_store #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WORD_WIDTH  = 84,
  parameter int CHUNK_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] CRADR,
  input  logic                  stall,
  input  logic [0:35]           EBUS,
  input  logic                  diagLoadAdr,
  input  logic                  diagWriteChunk,
  input  logic                  diagReadEn,
  input  logic [2:0]            diagReadSel,
  output logic [0:WORD_WIDTH-1] cramWord,
  output logic [10:0]           CRAM_J,
  output logic [4:0]            CRAM_DISP,
  output logic [5:0]            CRAM_COND,
  output logic                  CRAM_CALL,
  output logic                  CRAM_MARK,
  output logic                  loaderBusy,
  output logic                  loaderOverrun,
  output logic                  parityErr,
  output logic [35:0]           CRM_EBUS,
  output logic                  CRMdrivingEBUS
);

  localparam int NCHUNK = WORD_WIDTH / CHUNK_WIDTH;
  localparam logic [2:0] LAST_CHUNK = 3'(NCHUNK - 1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOADING, COMMIT} load_state_t;

  load_state_t           state, state_next;
  logic [2:0]            count;
  logic [0:WORD_WIDTH-1] staging;
  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [0:WORD_WIDTH-1] mem [0:(1<<ADDR_WIDTH)-1];
  logic                  ebus_unused;

  // Only the low chunk of EBUS carries loader data.
  assign ebus_unused = ^EBUS[0:35-CHUNK_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (diagLoadAdr) state_next = LOADING;
      LOADING: begin
        if (diagLoadAdr)
          state_next = LOADING;
        else if (diagWriteChunk && count == LAST_CHUNK)
          state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loader datapath; an address strobe always wins over a chunk in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      staging       <= '0;
      wr_adr        <= '0;
      loaderOverrun <= 1'b0;
      loaderBusy    <= 1'b0;
    end else begin
      loaderBusy <= (state_next != IDLE);
      if (diagLoadAdr && state != COMMIT) begin
        wr_adr  <= EBUS[36-ADDR_WIDTH:35];
        count   <= '0;
        staging <= '0;
      end else if (state == LOADING && diagWriteChunk) begin
        staging[count*CHUNK_WIDTH +: CHUNK_WIDTH] <= EBUS[36-CHUNK_WIDTH:35];
        count <= count + 3'd1;
      end else if (state == COMMIT) begin
        wr_adr <= wr_adr + ADR_ONE;
        count  <= '0;
      end
      if (diagLoadAdr)
        loaderOverrun <= 1'b0;
      else if (diagWriteChunk && state != LOADING)
        loaderOverrun <= 1'b1;
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && state == COMMIT)
      mem[wr_adr] <= staging;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cramWord <= '0;
    end else if (state == IDLE && !stall) begin
      cramWord <= mem[CRADR];
    end
  end

`ifdef CRAM_PARITY_CHECK_EN
  // Odd parity over the whole word; the error flag tracks cramWord updates.
  always_ff @(posedge clk) begin
    if (reset)
      parityErr <= 1'b0;
    else if (state == IDLE && !stall)
      parityErr <= ~(^mem[CRADR]);
  end
`else
  assign parityErr = 1'b0;
`endif

  assign CRAM_J    = cramWord[0:10];
  assign CRAM_DISP = cramWord[11:15];
  assign CRAM_COND = cramWord[16:21];
  assign CRAM_CALL = cramWord[22];
  assign CRAM_MARK = cramWord[23];

  always_comb begin
    CRM_EBUS = '0;
    if (diagReadEn && diagReadSel <= LAST_CHUNK)
      CRM_EBUS[CHUNK_WIDTH-1:0] = cramWord[diagReadSel*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  assign CRMdrivingEBUS = diagReadEn;

endmodule
